// File: rtl/otter_fetch_unit.sv
// ============================================================================
// otter_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch front end of the pipelined OTTER core.
//
// The unit sends pipelined requests to instruction memory. Returned words are
// buffered in a small FIFO together with their PCs. The decode stage consumes
// the head entry. When execute resolves a PC change, the FIFO is flushed and
// fetching restarts at the redirect target. Responses to requests that were
// already granted before the redirect are discarded in the DRAIN state.
//
// Optional build feature: define FETCH_PERF_CNT_EN to add the FE_STALL_CNT
// and FE_FLUSH_CNT performance counters.
//
// Ports
//   CLK, RST_N          core clock, asynchronous active-low reset
//   IMEM_REQ/ADDR/GNT   request handshake to instruction memory
//   IMEM_RVALID/RDATA   in-order response words
//   REDIRECT, PCSOURCE  PC change from execute (001 JALR, 010 BRANCH,
//                       011 JAL, 100 trap, 101 MRET; others ignored)
//   JALR_TGT .. MEPC    redirect target candidates
//   DE_READY            decode accepts the head instruction
//   DE_VALID/IR/PC      head instruction; IR reads as NOP when empty
//   DE_OPCODE/FUNC3/7   fields sliced from DE_IR for the control decoder
//   FE_STALL_CNT        (FETCH_PERF_CNT_EN) cycles decode waited on fetch
//   FE_FLUSH_CNT        (FETCH_PERF_CNT_EN) accepted redirects
// ============================================================================
module otter_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        CLK,
    input  logic        RST_N,

    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,

    input  logic        REDIRECT,
    input  logic [2:0]  PCSOURCE,
    input  logic [31:0] JALR_TGT,
    input  logic [31:0] BRANCH_TGT,
    input  logic [31:0] JAL_TGT,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,

    input  logic        DE_READY,
    output logic        DE_VALID,
    output logic [31:0] DE_IR,
    output logic [31:0] DE_PC,
    output logic [6:0]  DE_OPCODE,
    output logic [2:0]  DE_FUNC3,
    output logic [6:0]  DE_FUNC7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FE_STALL_CNT,
    output logic [31:0] FE_FLUSH_CNT
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_C   = SW'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]    state_q,  state_d;
    logic [31:0]   pc_q,     pc_d;      // next address to request
    logic [31:0]   rsp_pc_q, rsp_pc_d;  // PC of the next live response word
    logic [OW-1:0] out_q,    out_d;     // granted but not yet returned
    logic [OW-1:0] drop_q,   drop_d;    // stale responses still to discard
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          req_en_q;            // keeps IMEM_REQ low in the reset cycle

    logic [31:0]   fifo_ir [FIFO_DEPTH];
    logic [31:0]   fifo_pc [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Redirect decode
    // ------------------------------------------------------------------------
    logic        redirect_valid;
    logic [31:0] tgt_raw;
    logic [31:0] redirect_tgt;

    assign redirect_valid = REDIRECT && (PCSOURCE >= 3'd1) && (PCSOURCE <= 3'd5);

    always_comb begin
        tgt_raw = 32'h0;
        case (PCSOURCE)
            3'd1:    tgt_raw = JALR_TGT;
            3'd2:    tgt_raw = BRANCH_TGT;
            3'd3:    tgt_raw = JAL_TGT;
            3'd4:    tgt_raw = MTVEC;
            3'd5:    tgt_raw = MEPC;
            default: tgt_raw = 32'h0;
        endcase
    end

    assign redirect_tgt = {tgt_raw[31:2], 2'b00};

    // ------------------------------------------------------------------------
    // Request / handshake qualifiers
    // ------------------------------------------------------------------------
    logic [SW-1:0] occupancy;
    logic          req;
    logic          grant;
    logic          fifo_empty;
    logic          pop;
    logic          push;

    // Counting in-flight requests against FIFO space reserves a slot for every
    // word that can still come back, so a push never finds the FIFO full
    // without a matching pop.
    assign occupancy  = SW'(out_q) + SW'(cnt_q);
    assign req        = req_en_q && (state_q == ST_RUN) &&
                        (out_q < MAX_OUT_C) && (occupancy < DEPTH_C);
    assign grant      = req && IMEM_GNT;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = !fifo_empty && DE_READY;
    // A word returning in the redirect cycle belongs to the old stream.
    assign push       = IMEM_RVALID && (state_q == ST_RUN) && !redirect_valid;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        out_d = out_q;
        case ({grant, IMEM_RVALID})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale, including
            // a request granted in this very cycle.
            pc_d     = redirect_tgt;
            rsp_pc_d = redirect_tgt;
            drop_d   = out_d;
            state_d  = (out_d != '0) ? ST_DRAIN : ST_RUN;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if ((state_q == ST_DRAIN) && IMEM_RVALID) begin
                drop_d = drop_q - OW'(1);
                if (drop_q == OW'(1)) begin
                    state_d = ST_RUN;
                end
            end
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_en_q <= 1'b1;
        end
    end

    // FIFO storage: data is only observed while the entry is counted as valid,
    // so it needs no reset.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge CLK) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    fifo_ir[gi] <= IMEM_RDATA;
                    fifo_pc[gi] <= rsp_pc_q;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign IMEM_REQ  = req;
    assign IMEM_ADDR = pc_q;

    assign DE_VALID  = !fifo_empty;
    assign DE_IR     = fifo_empty ? NOP_INSTR : fifo_ir[rd_ptr_q];
    assign DE_PC     = fifo_empty ? 32'h0     : fifo_pc[rd_ptr_q];
    assign DE_OPCODE = DE_IR[6:0];
    assign DE_FUNC3  = DE_IR[14:12];
    assign DE_FUNC7  = DE_IR[31:25];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (DE_READY && fifo_empty) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect_valid) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FE_STALL_CNT = stall_cnt_q;
    assign FE_FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_otter_fetch_unit.sv
// ============================================================================
// tb_otter_fetch_unit
// ----------------------------------------------------------------------------
// Drives otter_fetch_unit with directed and randomized memory / decode /
// redirect traffic. The reference model tracks the fetch stream as queues:
// requests in flight (each tagged live or stale) and instructions buffered
// for decode, and derives every expected output from those.
// ============================================================================
module tb_otter_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [2:0]  PCSOURCE = 3'd0;
    logic [31:0] JALR_TGT = 32'h0;
    logic [31:0] BRANCH_TGT = 32'h0;
    logic [31:0] JAL_TGT = 32'h0;
    logic [31:0] MTVEC = 32'h0;
    logic [31:0] MEPC = 32'h0;
    logic        DE_READY = 1'b0;
    logic        DE_VALID;
    logic [31:0] DE_IR;
    logic [31:0] DE_PC;
    logic [6:0]  DE_OPCODE;
    logic [2:0]  DE_FUNC3;
    logic [6:0]  DE_FUNC7;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FE_STALL_CNT;
    logic [31:0] FE_FLUSH_CNT;
`endif

    always #5 CLK = ~CLK;

    otter_fetch_unit #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .PCSOURCE    (PCSOURCE),
        .JALR_TGT    (JALR_TGT),
        .BRANCH_TGT  (BRANCH_TGT),
        .JAL_TGT     (JAL_TGT),
        .MTVEC       (MTVEC),
        .MEPC        (MEPC),
        .DE_READY    (DE_READY),
        .DE_VALID    (DE_VALID),
        .DE_IR       (DE_IR),
        .DE_PC       (DE_PC),
        .DE_OPCODE   (DE_OPCODE),
        .DE_FUNC3    (DE_FUNC3),
        .DE_FUNC7    (DE_FUNC7)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FE_STALL_CNT(FE_STALL_CNT),
        .FE_FLUSH_CNT(FE_FLUSH_CNT)
`endif
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        bit          live;
    } req_t;

    req_t        mem_q[$];    // granted requests awaiting a response, in order
    logic [31:0] fifo_m[$];   // PCs of instructions buffered for decode
    logic [31:0] exp_addr;
    bit          exp_started;
    int          exp_stall;
    int          exp_flush;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hC3A5_0F13;
    endfunction

    function automatic bit exp_req();
        int stale = 0;
        foreach (mem_q[i]) if (!mem_q[i].live) stale++;
        return exp_started && (stale == 0) && (mem_q.size() < MAX_OUT) &&
               (mem_q.size() + fifo_m.size() < DEPTH);
    endfunction

    function automatic logic [31:0] pick_tgt(input logic [2:0] src);
        case (src)
            3'd1:    return JALR_TGT;
            3'd2:    return BRANCH_TGT;
            3'd3:    return JAL_TGT;
            3'd4:    return MTVEC;
            3'd5:    return MEPC;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle; entered and left at a falling edge.
    task automatic step(input bit gnt, input bit rv_en, input bit rdy,
                        input bit redir, input logic [2:0] src);
        bit          rv, grant, acc, pop, req_e;
        logic [31:0] w, tgt;
        req_t        r;

        rv          = rv_en && (mem_q.size() > 0);
        IMEM_GNT    = gnt;
        IMEM_RVALID = rv;
        IMEM_RDATA  = rv ? mem_word(mem_q[0].addr) : $urandom;
        DE_READY    = rdy;
        REDIRECT    = redir;
        PCSOURCE    = src;
        #1;

        req_e = exp_req();
        check("imem_req",  IMEM_REQ,  req_e);
        check("imem_addr", IMEM_ADDR, exp_addr);
        check("de_valid",  DE_VALID,  fifo_m.size() > 0);
        if (fifo_m.size() == 0) begin
            check("de_ir_nop", DE_IR, NOP_INSTR);
        end else begin
            w = mem_word(fifo_m[0]);
            check("de_pc",     DE_PC, fifo_m[0]);
            check("de_ir",     DE_IR, w);
            check("de_opcode", {25'b0, DE_OPCODE}, {25'b0, w[6:0]});
            check("de_func3",  {29'b0, DE_FUNC3},  {29'b0, w[14:12]});
            check("de_func7",  {25'b0, DE_FUNC7},  {25'b0, w[31:25]});
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", FE_STALL_CNT, exp_stall);
        check("flush_cnt", FE_FLUSH_CNT, exp_flush);
`endif

        grant = req_e && gnt;
        acc   = redir && (src >= 3'd1) && (src <= 3'd5);
        tgt   = pick_tgt(src);
        pop   = (fifo_m.size() > 0) && rdy;

        if (rdy && (fifo_m.size() == 0)) exp_stall++;
        if (pop) begin
            $display("decode pc=%h ir=%h", fifo_m[0], mem_word(fifo_m[0]));
            void'(fifo_m.pop_front());
        end
        if (rv) begin
            r = mem_q.pop_front();
            if (r.live && !acc) fifo_m.push_back(r.addr);
        end
        if (grant) begin
            mem_q.push_back('{addr: exp_addr, live: !acc});
            exp_addr = exp_addr + 32'd4;
        end
        if (acc) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            fifo_m.delete();
            exp_addr = {tgt[31:2], 2'b00};
            exp_flush++;
            $display("redirect src=%0d target=%h", src, exp_addr);
        end
        exp_started = 1'b1;
        @(negedge CLK);
    endtask

    // Asserts reset shortly after a falling edge and checks that outputs
    // respond before any clock edge; releases it at the following falling edge.
    task automatic apply_reset();
        #2;
        RST_N       = 1'b0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        REDIRECT    = 1'b0;
        DE_READY    = 1'b0;
        #1;
        check("rst_req",   IMEM_REQ,  1'b0);
        check("rst_addr",  IMEM_ADDR, RESET_PC);
        check("rst_valid", DE_VALID,  1'b0);
        check("rst_ir",    DE_IR,     NOP_INSTR);
        check("rst_pc",    DE_PC,     32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall", FE_STALL_CNT, 32'h0);
        check("rst_flush", FE_FLUSH_CNT, 32'h0);
`endif
        mem_q.delete();
        fifo_m.delete();
        exp_addr    = RESET_PC;
        exp_started = 1'b0;
        exp_stall   = 0;
        exp_flush   = 0;
        $display("reset asserted");
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic fill_outstanding();
        for (int i = 0; i < 10 && mem_q.size() < MAX_OUT; i++) step(1, 0, 1, 0, 3'd0);
    endtask

    initial begin
        @(negedge CLK);
        apply_reset();

        // Streaming: always granted, one-cycle memory, decode always ready.
        repeat (20) step(1, 1, 1, 0, 3'd0);

        // Decode back-pressure fills the buffer, then release it.
        repeat (10) step(1, 1, 0, 0, 3'd0);
        check("full_req_low", IMEM_REQ, 1'b0);
        repeat (10) step(1, 1, 1, 0, 3'd0);

        // JAL with two requests outstanding, then trap and MRET while draining.
        fill_outstanding();
        JAL_TGT = 32'h0000_0100;
        step(0, 0, 1, 1, 3'd3);
        MTVEC = 32'h0000_0203;
        step(0, 0, 1, 1, 3'd4);
        check("drain_align", IMEM_ADDR, 32'h0000_0200);
        MEPC = 32'h0000_0040;
        step(0, 0, 1, 1, 3'd5);
        repeat (12) step(1, 1, 1, 0, 3'd0);

        // Redirect together with grant and response; then a PCSOURCE=000 no-op.
        step(1, 0, 1, 0, 3'd0);
        JALR_TGT = 32'h0000_0302;
        step(1, 1, 1, 1, 3'd1);
        step(1, 1, 1, 1, 3'd0);
        repeat (10) step(1, 1, 1, 0, 3'd0);

        // Randomized traffic, including ignored PCSOURCE encodings.
        for (int n = 0; n < 300; n++) begin
            JALR_TGT   = $urandom;
            BRANCH_TGT = $urandom;
            JAL_TGT    = $urandom;
            MTVEC      = $urandom;
            MEPC       = $urandom;
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                 ($urandom % 10) == 0, 3'($urandom_range(0, 7)));
        end

        // Reset while draining two stale requests.
        repeat (6) step(1, 1, 1, 0, 3'd0);
        fill_outstanding();
        BRANCH_TGT = 32'h0000_0800;
        step(0, 0, 1, 1, 3'd2);
        step(0, 0, 1, 0, 3'd0);
        apply_reset();
        repeat (15) step(1, 1, 1, 0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
